// File: rtl/fp_addsub_issuer_if.sv
// Request, functional-unit and response signals between the F-extension execute
// stage, the add/sub issuer and its add_sub_fp instance.
interface fp_addsub_issuer_if #(
  parameter int Size = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_sub;
  logic [2:0]      req_rm;
  logic [Size-1:0] req_a;
  logic [Size-1:0] req_b;

  logic            fu_start;
  logic            fu_sub;
  logic [2:0]      fu_rm;
  logic [Size-1:0] fu_a;
  logic [Size-1:0] fu_b;
  logic            fu_done;
  logic [Size-1:0] fu_result;
  logic            fu_nv;
  logic            fu_of;
  logic            fu_uf;
  logic            fu_nx;

  logic            resp_valid;
  logic            resp_ready;
  logic [Size-1:0] resp_result;
  logic [4:0]      resp_flags;
  logic            resp_illegal;
  logic            resp_timeout;

  modport slave (
    input  req_valid, req_sub, req_rm, req_a, req_b,
    input  fu_done, fu_result, fu_nv, fu_of, fu_uf, fu_nx,
    input  resp_ready,
    output req_ready, fu_start, fu_sub, fu_rm, fu_a, fu_b,
    output resp_valid, resp_result, resp_flags, resp_illegal, resp_timeout
  );

  modport master (
    output req_valid, req_sub, req_rm, req_a, req_b,
    output fu_done, fu_result, fu_nv, fu_of, fu_uf, fu_nx,
    output resp_ready,
    input  req_ready, fu_start, fu_sub, fu_rm, fu_a, fu_b,
    input  resp_valid, resp_result, resp_flags, resp_illegal, resp_timeout
  );
endinterface

// File: rtl/fp_addsub_issuer.sv
// Issues one FADD/FSUB at a time to an add_sub_fp unit: resolves the rounding mode,
// drives start, waits for done under a watchdog, and accrues {NV,DZ,OF,UF,NX}.
module fp_addsub_issuer #(
  parameter int Size    = 64,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_addsub_issuer_if.slave bus,
  input  logic [2:0]        frm,
  input  logic              fflags_clr,
  output logic [4:0]        fflags
);
  localparam int CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      eff_rm;
  logic            rm_illegal;
  logic            accept;
  logic            capture;
  logic            wd_expired;
  logic [CntW-1:0] wd_cnt;
  logic [4:0]      cap_flags;

  logic            sub_lat;
  logic [2:0]      rm_lat;
  logic [Size-1:0] a_lat;
  logic [Size-1:0] b_lat;
  logic [Size-1:0] res_lat;
  logic [4:0]      flags_lat;
  logic            illegal_lat;
  logic            timeout_lat;

  assign eff_rm     = (bus.req_rm == 3'b111) ? frm : bus.req_rm;
  assign rm_illegal = (eff_rm == 3'b101) || (eff_rm == 3'b110) || (eff_rm == 3'b111);
  assign accept     = (state == IDLE) && bus.req_valid;
  assign capture    = (state == WAIT) && bus.fu_done;
  // Last WAIT cycle is the TIMEOUT-th one; a done arriving in it still wins.
  assign wd_expired = (wd_cnt == CntW'(TIMEOUT - 1));
  assign cap_flags  = {bus.fu_nv, 1'b0, bus.fu_of, bus.fu_uf, bus.fu_nx};

  assign bus.fu_sub       = sub_lat;
  assign bus.fu_rm        = rm_lat;
  assign bus.fu_a         = a_lat;
  assign bus.fu_b         = b_lat;
  assign bus.resp_result  = res_lat;
  assign bus.resp_flags   = flags_lat;
  assign bus.resp_illegal = illegal_lat;
  assign bus.resp_timeout = timeout_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.fu_start   = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = rm_illegal ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.fu_start = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (bus.fu_done || wd_expired) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_lat     <= 1'b0;
      rm_lat      <= 3'b000;
      a_lat       <= '0;
      b_lat       <= '0;
      res_lat     <= '0;
      flags_lat   <= 5'b00000;
      illegal_lat <= 1'b0;
      timeout_lat <= 1'b0;
      wd_cnt      <= '0;
      fflags      <= 5'b00000;
    end else begin
      if (accept) begin
        sub_lat <= bus.req_sub;
        rm_lat  <= eff_rm;
        a_lat   <= bus.req_a;
        b_lat   <= bus.req_b;
        if (rm_illegal) begin
          res_lat     <= '0;
          flags_lat   <= 5'b00000;
          illegal_lat <= 1'b1;
          timeout_lat <= 1'b0;
        end
      end

      if (state == ISSUE)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + CntW'(1);

      if (capture) begin
        res_lat     <= bus.fu_result;
        flags_lat   <= cap_flags;
        illegal_lat <= 1'b0;
        timeout_lat <= 1'b0;
      end else if ((state == WAIT) && wd_expired) begin
        res_lat     <= '0;
        flags_lat   <= 5'b00000;
        illegal_lat <= 1'b0;
        timeout_lat <= 1'b1;
      end

      // A clear coinciding with a capture leaves only this op's flags.
      if (capture)         fflags <= (fflags_clr ? 5'b00000 : fflags) | cap_flags;
      else if (fflags_clr) fflags <= 5'b00000;
    end
  end
endmodule

// File: tb/tb_fp_addsub_issuer.sv
// Bench for fp_addsub_issuer: a 64-bit instance checked every cycle against a
// transaction-level model, plus a 32-bit instance driven by directed vectors.
module tb_fp_addsub_issuer;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] frm64, frm32;
  logic       clr_main, clr_stub, clr64, clr32;
  logic [4:0] fflags64, fflags32;
  logic       stub_done, force_done, stub_en, clr_on_done;
  int         stub_lat, stub_cnt;
  logic [2:0] last_rm;

  int checks = 0;
  int failures = 0;

  fp_addsub_issuer_if #(.Size(64)) d64 ();
  fp_addsub_issuer_if #(.Size(32)) d32 ();

  assign clr64       = clr_main | clr_stub;
  assign d64.fu_done = stub_done | force_done;

  fp_addsub_issuer #(.Size(64), .TIMEOUT(TO)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(d64.slave), .frm(frm64),
    .fflags_clr(clr64), .fflags(fflags64)
  );

  fp_addsub_issuer #(.Size(32), .TIMEOUT(256)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(d32.slave), .frm(frm32),
    .fflags_clr(clr32), .fflags(fflags32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-computed IEEE results for the vectors used; anything else gets a tag value.
  function automatic void fu_lookup(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                    output logic [63:0] r, output logic [3:0] f);
    r = a ^ b ^ {63'b0, sub};
    f = 4'b0000;
    if (a == 64'h3FF8000000000000 && b == 64'hBFF8000000000000 && sub)
      r = 64'h4008000000000000;
    else if (a == 64'h7FEFF00000000001 && b == 64'h7FE0000000000000 && !sub) begin
      r = 64'h7FF0000000000000; f = 4'b0101;
    end else if (a == 64'h7FF0000000000000 && b == 64'hFFF0000000000000 && !sub) begin
      r = 64'h7FF8000000000000; f = 4'b1000;
    end
  endfunction

  // add_sub_fp stand-in for the 64-bit instance
  initial begin
    logic [63:0] r;
    logic [3:0]  f;
    stub_done = 1'b0; clr_stub = 1'b0; stub_cnt = 0; last_rm = 3'b000;
    d64.fu_result = '0;
    {d64.fu_nv, d64.fu_of, d64.fu_uf, d64.fu_nx} = 4'b0000;
    forever begin
      @(posedge clk); #1;
      stub_done = 1'b0;
      clr_stub  = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_done = 1'b1;
          clr_stub  = clr_on_done;
        end
      end
      if (stub_en && d64.fu_start) begin
        stub_cnt = stub_lat;
        last_rm  = d64.fu_rm;
        fu_lookup(d64.fu_a, d64.fu_b, d64.fu_sub, r, f);
        d64.fu_result = r;
        {d64.fu_nv, d64.fu_of, d64.fu_uf, d64.fu_nx} = f;
      end
    end
  end

  // Transaction model of the 64-bit instance, expressed as event cycles
  int          cyc = 0;
  logic        m_busy, m_ill, m_to, m_sub, exp_rv, got_cap;
  int          m_issue, m_ws, m_resp;
  logic [63:0] m_a, m_b, m_res;
  logic [2:0]  m_rm;
  logic [4:0]  m_flags, m_ff;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_ill = 1'b0; m_to = 1'b0; m_ff = 5'b0;
      m_issue = -100; m_resp = -1;
      chk("rst_req_ready", d64.req_ready, 1);
      chk("rst_fu_start", d64.fu_start, 0);
      chk("rst_resp_valid", d64.resp_valid, 0);
      chk("rst_resp_result", d64.resp_result, 0);
      chk("rst_fu_a", d64.fu_a, 0);
      chk("rst_fflags", fflags64, 0);
    end else begin
      exp_rv = m_busy && (m_resp >= 0) && (cyc >= m_resp);
      chk("req_ready", d64.req_ready, !m_busy);
      chk("fu_start", d64.fu_start, m_busy && !m_ill && (cyc == m_issue));
      chk("resp_valid", d64.resp_valid, exp_rv);
      if (exp_rv) begin
        chk("resp_result", d64.resp_result, m_res);
        chk("resp_flags", d64.resp_flags, m_flags);
        chk("resp_illegal", d64.resp_illegal, m_ill);
        chk("resp_timeout", d64.resp_timeout, m_to);
      end
      if (m_busy && !m_ill && (cyc >= m_issue) && !exp_rv) begin
        chk("fu_a", d64.fu_a, m_a);
        chk("fu_b", d64.fu_b, m_b);
        chk("fu_sub", d64.fu_sub, m_sub);
        chk("fu_rm", d64.fu_rm, m_rm);
      end
      chk("fflags", fflags64, m_ff);

      got_cap = 1'b0;
      if (!m_busy) begin
        if (d64.req_valid) begin
          m_busy = 1'b1; m_sub = d64.req_sub; m_a = d64.req_a; m_b = d64.req_b;
          m_rm   = (d64.req_rm == 3'b111) ? frm64 : d64.req_rm;
          m_ill  = (m_rm >= 3'd5);
          m_to   = 1'b0;
          if (m_ill) begin
            m_resp = cyc + 1; m_res = '0; m_flags = 5'b0;
          end else begin
            m_issue = cyc + 1; m_ws = cyc + 2; m_resp = -1;
          end
        end
      end else if (exp_rv) begin
        if (d64.resp_ready) m_busy = 1'b0;
      end else if (!m_ill && (m_resp < 0) && (cyc >= m_ws)) begin
        if (d64.fu_done) begin
          m_resp  = cyc + 1;
          m_res   = d64.fu_result;
          m_flags = {d64.fu_nv, 1'b0, d64.fu_of, d64.fu_uf, d64.fu_nx};
          m_ff    = (clr64 ? 5'b0 : m_ff) | m_flags;
          got_cap = 1'b1;
        end else if (cyc == m_ws + TO - 1) begin
          m_resp = cyc + 1; m_to = 1'b1; m_res = '0; m_flags = 5'b0;
        end
      end
      if (clr64 && !got_cap) m_ff = 5'b0;
    end
    cyc++;
  end

  int start_seen = 0;
  always @(negedge clk) if (d64.fu_start) start_seen++;

  task automatic req64(input logic sub, input logic [2:0] rm, input logic [63:0] a, input logic [63:0] b);
    logic got;
    got = 1'b0;
    d64.req_sub = sub; d64.req_rm = rm; d64.req_a = a; d64.req_b = b; d64.req_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); got = d64.req_ready;
      @(posedge clk); #1;
    end
    d64.req_valid = 1'b0;
    chk("req_accepted", got, 1);
  endtask

  task automatic wait_resp64(output logic [63:0] res, output logic [4:0] fl,
                             output logic ill, output logic tmo, output int n);
    logic got;
    got = 1'b0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (d64.resp_valid) got = 1'b1;
      else n++;
    end
    chk("resp_arrived", got, 1);
    res = d64.resp_result; fl = d64.resp_flags; ill = d64.resp_illegal; tmo = d64.resp_timeout;
    @(posedge clk); #1;
  endtask

  logic [63:0] r;
  logic [4:0]  fl, ff_before;
  logic        il, tmo;
  int          n, s0, starts;

  initial begin
    rst_n = 1'b0;
    frm64 = 3'b000; frm32 = 3'b000; clr_main = 1'b0; clr32 = 1'b0;
    force_done = 1'b0; stub_en = 1'b1; stub_lat = 1; clr_on_done = 1'b0;
    d64.req_valid = 1'b0; d64.req_sub = 1'b0; d64.req_rm = 3'b000; d64.req_a = '0; d64.req_b = '0;
    d64.resp_ready = 1'b1;
    d32.req_valid = 1'b0; d32.req_sub = 1'b0; d32.req_rm = 3'b000; d32.req_a = '0; d32.req_b = '0;
    d32.resp_ready = 1'b1; d32.fu_done = 1'b0; d32.fu_result = '0;
    {d32.fu_nv, d32.fu_of, d32.fu_uf, d32.fu_nx} = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst32_req_ready", d32.req_ready, 1);
    chk("rst32_fflags", fflags32, 0);

    // single-precision add, start pulse width and pass-through
    d32.req_a = 32'h3E800000; d32.req_b = 32'h42C80000; d32.req_valid = 1'b1;
    @(posedge clk); #1;
    d32.req_valid = 1'b0;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d32.fu_start) starts++;
      chk("t1_fu_a", d32.fu_a, 32'h3E800000);
    end
    chk("t1_start_cycles", starts, 1);
    @(posedge clk); #1;
    d32.fu_done = 1'b1; d32.fu_result = 32'h42C88000;
    @(posedge clk); #1;
    d32.fu_done = 1'b0;
    @(negedge clk);
    chk("t1_resp_valid", d32.resp_valid, 1);
    chk("t1_result", d32.resp_result, 32'h42C88000);
    chk("t1_flags", d32.resp_flags, 5'b00000);
    @(posedge clk); #1;

    // dynamic rounding, double-precision subtract at minimum latency
    req64(1'b1, 3'b111, 64'h3FF8000000000000, 64'hBFF8000000000000);
    wait_resp64(r, fl, il, tmo, n);
    chk("t2_result", r, 64'h4008000000000000);
    chk("t2_fu_rm", last_rm, 3'b000);
    chk("t2_accept_to_resp", n + 1, 3);
    frm64 = 3'b011;
    req64(1'b0, 3'b111, 64'h1, 64'h2);
    wait_resp64(r, fl, il, tmo, n);
    chk("t2_fu_rm_dyn", last_rm, 3'b011);
    req64(1'b0, 3'b100, 64'h5, 64'h3);
    wait_resp64(r, fl, il, tmo, n);
    chk("t2_fu_rm_static", last_rm, 3'b100);
    chk("t2_tag_result", r, 64'h6);

    // overflow then invalid, accrued flags and clear
    frm64 = 3'b000; stub_lat = 3;
    req64(1'b0, 3'b000, 64'h7FEFF00000000001, 64'h7FE0000000000000);
    wait_resp64(r, fl, il, tmo, n);
    chk("t3_ovf_result", r, 64'h7FF0000000000000);
    chk("t3_ovf_flags", fl, 5'b00101);
    chk("t3_ovf_fflags", fflags64, 5'b00101);
    req64(1'b0, 3'b000, 64'h7FF0000000000000, 64'hFFF0000000000000);
    wait_resp64(r, fl, il, tmo, n);
    chk("t3_nv_flags", fl, 5'b10000);
    chk("t3_nv_fflags", fflags64, 5'b10101);
    clr_main = 1'b1;
    @(posedge clk); #1;
    clr_main = 1'b0;
    chk("t3_clr_fflags", fflags64, 5'b00000);
    req64(1'b0, 3'b000, 64'h7FEFF00000000001, 64'h7FE0000000000000);
    wait_resp64(r, fl, il, tmo, n);
    clr_on_done = 1'b1;
    req64(1'b0, 3'b000, 64'h7FF0000000000000, 64'hFFF0000000000000);
    wait_resp64(r, fl, il, tmo, n);
    clr_on_done = 1'b0;
    chk("t3_clr_with_capture", fflags64, 5'b10000);

    // illegal rounding modes
    s0 = start_seen;
    req64(1'b0, 3'b101, 64'h11, 64'h22);
    wait_resp64(r, fl, il, tmo, n);
    chk("t4_illegal_101", il, 1);
    chk("t4_result_zero", r, 0);
    frm64 = 3'b110;
    req64(1'b1, 3'b111, 64'h11, 64'h22);
    wait_resp64(r, fl, il, tmo, n);
    chk("t4_illegal_dyn110", il, 1);
    chk("t4_no_start", start_seen - s0, 0);
    chk("t4_fflags_kept", fflags64, 5'b10000);
    frm64 = 3'b000;

    // watchdog, then a stray done while idle
    stub_en = 1'b0;
    req64(1'b0, 3'b000, 64'h7FEFF00000000001, 64'h7FE0000000000000);
    wait_resp64(r, fl, il, tmo, n);
    chk("t5_timeout", tmo, 1);
    chk("t5_wait_cycles", n - 1, TO);
    chk("t5_flags_zero", fl, 0);
    chk("t5_fflags_kept", fflags64, 5'b10000);
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_late_done_idle", d64.req_ready, 1);
    chk("t5_late_done_no_resp", d64.resp_valid, 0);
    @(posedge clk); #1;
    stub_en = 1'b1; stub_lat = 2;

    // back-pressure on the response
    d64.resp_ready = 1'b0;
    req64(1'b1, 3'b010, 64'hA5A5, 64'h0F0F);
    wait_resp64(r, fl, il, tmo, n);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", d64.resp_valid, 1);
      chk("t6_hold_result", d64.resp_result, r);
      chk("t6_hold_req_ready", d64.req_ready, 0);
      @(posedge clk); #1;
    end
    d64.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_released", d64.req_ready, 1);

    // asynchronous reset while waiting for done
    stub_en = 1'b0;
    req64(1'b0, 3'b000, 64'h1234, 64'h5678);
    repeat (3) @(negedge clk);
    ff_before = fflags64;
    chk("t6_pre_fflags", ff_before, 5'b10000);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_req_ready", d64.req_ready, 1);
    chk("t6_async_fu_start", d64.fu_start, 0);
    chk("t6_async_fu_a", d64.fu_a, 0);
    chk("t6_async_resp_valid", d64.resp_valid, 0);
    chk("t6_async_result", d64.resp_result, 0);
    chk("t6_async_fflags", fflags64, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stub_en = 1'b1; stub_lat = 1;
    repeat (12) @(posedge clk);
    #1;
    req64(1'b1, 3'b111, 64'h3FF8000000000000, 64'hBFF8000000000000);
    wait_resp64(r, fl, il, tmo, n);
    chk("t6_after_reset_result", r, 64'h4008000000000000);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1);
  end
endmodule
